// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_LEADING_BLANK_EN replaces leading zero digits with 4'hF on output.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic [WIDTH-1:0]    mag_q;
  logic [CW-1:0]       count_q;
  logic                negR_q;
  logic                nonZero_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;
  logic                busy_q;
  logic                done_q;

  logic                negIn_d;
  logic [WIDTH-1:0]    magIn_d;
  logic [4*DIGITS-1:0] adjusted_d;
  logic [4*DIGITS-1:0] blanked_d;

  // Two's-complement negate stays WIDTH bits; -2^(WIDTH-1) maps onto itself as the unsigned magnitude.
  always_comb begin
    negIn_d = SIGNED && value[WIDTH-1];
    magIn_d = negIn_d ? (~value + 1'b1) : value;
  end

  always_comb begin
    adjusted_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef BCD_LEADING_BLANK_EN
    logic leading;
    leading   = 1'b1;
    blanked_d = scratch_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (scratch_q[4*i +: 4] == 4'd0))
        blanked_d[4*i +: 4] = 4'hF;
      else
        leading = 1'b0;
    end
`else
    blanked_d = scratch_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      mag_q     <= '0;
      count_q   <= '0;
      negR_q    <= 1'b0;
      nonZero_q <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mag_q     <= magIn_d;
            negR_q    <= negIn_d;
            nonZero_q <= |value;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= {adjusted_d[4*DIGITS-2:0], mag_q[WIDTH-1]};
          mag_q     <= mag_q << 1;
          count_q   <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1))
            state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= blanked_d;
          neg_q   <= negR_q && nonZero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign neg  = neg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a signed and an unsigned instance share stimulus.
module tb_bin_to_bcd_seq;

   typedef struct {
      logic [15:0] value;
      logic [19:0] bcdS;
      logic        negS;
      logic [19:0] bcdU;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] value = '0;
   logic [19:0] bcdS, bcdU;
   logic        negS, negU, busyS, busyU, doneS, doneU;

   int compared   = 0;
   int mismatched = 0;

   vec_t vecs[11];

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dutS (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .bcd(bcdS), .neg(negS), .busy(busyS), .done(doneS)
   );

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dutU (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .bcd(bcdU), .neg(negU), .busy(busyU), .done(doneU)
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   // Expected display form of a plain BCD number, blanking leading zeros when enabled
   function automatic logic [19:0] expectDisp(input logic [19:0] raw);
      logic [19:0] r;
      r = raw;
`ifdef BCD_LEADING_BLANK_EN
      for (int i = 4; i >= 1; i--) begin
         if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
         else break;
      end
`endif
      return r;
   endfunction

   // Compare one observed value against its expectation and log any difference
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive a start request so that the next rising edge accepts it
   task automatic applyStimulus(input logic [15:0] v);
      @(negedge clock);
      start = 1'b1;
      value = v;
      @(posedge clock);
   endtask

   // Wait for the done pulse after an accepted start; value is scrambled to prove it was captured
   task automatic waitDone(input string name, output int cycles);
      @(negedge clock);
      start  = 1'b0;
      value  = 16'($urandom);
      cycles = 1;
      checkOutput({name, " busy after start"}, 32'(busyS), 32'd1);
      while (!doneS && cycles < 40) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput({name, " latency"}, 32'(cycles), 32'd18);
      checkOutput({name, " busy in done cycle"}, 32'(busyS), 32'd0);
      checkOutput({name, " unsigned done"}, 32'(doneU), 32'd1);
   endtask

   initial begin
      int cycles;
      int donePulses;

      vecs[0]  = '{16'd12345, 20'h12345, 1'b0, 20'h12345};
      vecs[1]  = '{16'hFFFF,  20'h00001, 1'b1, 20'h65535};
      vecs[2]  = '{16'h8000,  20'h32768, 1'b1, 20'h32768};
      vecs[3]  = '{16'd0,     20'h00000, 1'b0, 20'h00000};
      vecs[4]  = '{16'd42,    20'h00042, 1'b0, 20'h00042};
      vecs[5]  = '{16'hFECF,  20'h00305, 1'b1, 20'h65231};
      vecs[6]  = '{16'h7FFF,  20'h32767, 1'b0, 20'h32767};
      vecs[7]  = '{16'd9,     20'h00009, 1'b0, 20'h00009};
      vecs[8]  = '{16'd100,   20'h00100, 1'b0, 20'h00100};
      vecs[9]  = '{16'd59999, 20'h05537, 1'b1, 20'h59999};
      vecs[10] = '{16'd9090,  20'h09090, 1'b0, 20'h09090};

      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset bcd", 32'(bcdS), 32'd0);
      checkOutput("reset neg", 32'(negS), 32'd0);
      checkOutput("reset busy", 32'(busyS), 32'd0);
      checkOutput("reset done", 32'(doneS), 32'd0);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].value);
         waitDone($sformatf("vec%0d", i), cycles);
         checkOutput($sformatf("vec%0d bcd", i), 32'(bcdS), 32'(expectDisp(vecs[i].bcdS)));
         checkOutput($sformatf("vec%0d neg", i), 32'(negS), 32'(vecs[i].negS));
         checkOutput($sformatf("vec%0d ubcd", i), 32'(bcdU), 32'(expectDisp(vecs[i].bcdU)));
         checkOutput($sformatf("vec%0d uneg", i), 32'(negU), 32'd0);
         @(negedge clock);
         checkOutput($sformatf("vec%0d done width", i), 32'(doneS), 32'd0);
         checkOutput($sformatf("vec%0d bcd hold", i), 32'(bcdS), 32'(expectDisp(vecs[i].bcdS)));
      end

      // Start pulsed mid-conversion is ignored; start in the done cycle is accepted
      applyStimulus(16'd999);
      @(negedge clock);
      start = 1'b0;
      cycles = 1;
      donePulses = 0;
      while (!doneS && cycles < 40) begin
         @(negedge clock);
         cycles++;
         if (cycles == 5) begin start = 1'b1; value = 16'd123; end
         else start = 1'b0;
         if (doneS) donePulses++;
      end
      checkOutput("ignore latency", 32'(cycles), 32'd18);
      checkOutput("ignore pulses", 32'(donePulses), 32'd1);
      checkOutput("ignore bcd", 32'(bcdS), 32'(expectDisp(20'h00999)));
      start = 1'b1;
      value = 16'd7;
      @(posedge clock);
      waitDone("b2b", cycles);
      checkOutput("b2b bcd", 32'(bcdS), 32'(expectDisp(20'h00007)));
      checkOutput("b2b neg", 32'(negS), 32'd0);

      // Reset mid-conversion aborts with no done pulse
      applyStimulus(16'hFFFF);
      waitDone("preReset", cycles);
      applyStimulus(16'd12345);
      @(negedge clock);
      start = 1'b0;
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("abort busy", 32'(busyS), 32'd0);
      checkOutput("abort bcd", 32'(bcdS), 32'd0);
      checkOutput("abort neg", 32'(negS), 32'd0);
      donePulses = 0;
      for (int c = 0; c < 25; c++) begin
         if (doneS) donePulses++;
         @(negedge clock);
      end
      checkOutput("abort no done", 32'(donePulses), 32'd0);
      applyStimulus(16'd4321);
      waitDone("postReset", cycles);
      checkOutput("postReset bcd", 32'(bcdS), 32'(expectDisp(20'h04321)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
